// File: rtl/qtcore_pkg.sv
// Shared constants for the qtcore-A1 Tiny-Tapeout core: state codes, opcodes,
// memory map and scan-chain geometry.
package qtcore_pkg;

  localparam int unsigned MEM_BYTES = 17;
  localparam int unsigned RAM_BYTES = 16;
  localparam int unsigned SCAN_LEN  = 24 + MEM_BYTES * 8;
  localparam logic [4:0]  IO_ADDR   = 5'd16;

  typedef enum logic [2:0] {
    ST_FETCH = 3'b001,
    ST_EXEC  = 3'b010,
    ST_HALT  = 3'b100
  } state_e;

  // Major opcodes in IR[7:5]
  localparam logic [2:0] OP_LDA = 3'b000, OP_STA = 3'b001, OP_ADD = 3'b010,
                         OP_SUB = 3'b011, OP_AND = 3'b100, OP_OR  = 3'b101,
                         OP_XOR = 3'b110;

  // Immediate / control groups in IR[7:4]
  localparam logic [3:0] GRP_NOPI = 4'hC, GRP_LUI = 4'hD, GRP_ADDI = 4'hE,
                         GRP_F    = 4'hF;

  // F-group operations in IR[3:0]
  localparam logic [3:0] F_JMP  = 4'h0, F_NOP  = 4'h1, F_BEQF = 4'h2, F_BEQB = 4'h3,
                         F_BNEF = 4'h4, F_BNEB = 4'h5, F_SHL  = 4'h6, F_SHR  = 4'h7,
                         F_SHL4 = 4'h8, F_ROL  = 4'h9, F_ROR  = 4'hA, F_LDAR = 4'hB,
                         F_DEC  = 4'hC, F_CLR  = 4'hD, F_INV  = 4'hE, F_HLT  = 4'hF;

endpackage

// File: rtl/kiwih_qtcore_tt_if.sv
// Tiny-Tapeout pin ring: 8 inputs into the core, 8 outputs back to the pads.
interface kiwih_qtcore_tt_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);
endinterface

// File: rtl/qtcore_scan_reg.sv
// Parallel-load register with async clear and a serial scan path; scan shift
// beats load, MSB is the serial output.
module qtcore_scan_reg #(
  parameter int unsigned W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         scan_en_i,
  input  logic         scan_in_i,
  input  logic         load_en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         scan_out_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (scan_en_i) begin
      q_d = W'({q_q, scan_in_i});
    end else if (load_en_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o        = q_q;
  assign scan_out_o = q_q[W-1];

endmodule

// File: rtl/kiwih_qtcore_tt_top.sv
// qtcore-A1 accumulator CPU on the TT pin ring. Every architectural bit lives in
// a daisy-chained scan register; control, ALU and memory decode are here.
module kiwih_qtcore_tt_top (
  kiwih_qtcore_tt_if.slave tt
);
  import qtcore_pkg::*;

  logic clk, rst_n, scan_en, proc_en, scan_in, btn;
  logic unused_io;

  assign clk       = tt.io_in[0];
  assign rst_n     = tt.io_in[1];
  assign scan_en   = ~tt.io_in[2];
  assign proc_en   = ~tt.io_in[3];
  assign scan_in   = tt.io_in[4];
  assign btn       = tt.io_in[5];
  assign unused_io = &{1'b0, tt.io_in[7:6]};

  logic [2:0] state_q, state_d;
  logic [4:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d, acc_q, acc_d;
  logic [7:0] mem_q [MEM_BYTES];
  logic [7:0] mem_map [32];
  logic [7:0] io_d, rd_pc, rd_a, rd_acc;
  logic       sc_state, sc_pc, sc_ir, sc_acc;
  logic [MEM_BYTES-1:0] sc_mem;
  logic       mem_we, halted;
  logic [4:0] mem_wa;
  state_e     cur;

  // Chain order S[0]..S[159]: state, PC, IR, ACC, M0..M16
  qtcore_scan_reg #(.W(3), .RST_VAL(ST_FETCH)) u_state (
    .clk_i(clk), .rst_ni(rst_n), .scan_en_i(scan_en), .scan_in_i(scan_in),
    .load_en_i(proc_en), .d_i(state_d), .q_o(state_q), .scan_out_o(sc_state));

  qtcore_scan_reg #(.W(5)) u_pc (
    .clk_i(clk), .rst_ni(rst_n), .scan_en_i(scan_en), .scan_in_i(sc_state),
    .load_en_i(proc_en), .d_i(pc_d), .q_o(pc_q), .scan_out_o(sc_pc));

  qtcore_scan_reg #(.W(8)) u_ir (
    .clk_i(clk), .rst_ni(rst_n), .scan_en_i(scan_en), .scan_in_i(sc_pc),
    .load_en_i(proc_en), .d_i(ir_d), .q_o(ir_q), .scan_out_o(sc_ir));

  qtcore_scan_reg #(.W(8)) u_acc (
    .clk_i(clk), .rst_ni(rst_n), .scan_en_i(scan_en), .scan_in_i(sc_ir),
    .load_en_i(proc_en), .d_i(acc_d), .q_o(acc_q), .scan_out_o(sc_acc));

  for (genvar n = 0; n < MEM_BYTES; n++) begin : g_mem
    logic       sin, ld;
    logic [7:0] d;
    if (n == 0) begin : g_head
      assign sin = sc_acc;
    end else begin : g_link
      assign sin = sc_mem[n-1];
    end
    if (n == MEM_BYTES - 1) begin : g_io
      // IO byte reloads every non-scan clock so IO[0] tracks the button
      assign ld = 1'b1;
      assign d  = io_d;
    end else begin : g_ram
      assign ld = proc_en & mem_we & (mem_wa == 5'(n));
      assign d  = acc_q;
    end
    qtcore_scan_reg #(.W(8)) u_cell (
      .clk_i(clk), .rst_ni(rst_n), .scan_en_i(scan_en), .scan_in_i(sin),
      .load_en_i(ld), .d_i(d), .q_o(mem_q[n]), .scan_out_o(sc_mem[n]));
  end

  always_comb begin
    for (int unsigned i = 0; i < MEM_BYTES; i++) mem_map[i] = mem_q[i];
    for (int unsigned i = MEM_BYTES; i < 32; i++) mem_map[i] = '0;
  end

  assign rd_pc  = mem_map[pc_q];
  assign rd_a   = mem_map[ir_q[4:0]];
  assign rd_acc = mem_map[acc_q[4:0]];
  assign io_d   = {(proc_en && mem_we && mem_wa == IO_ADDR) ? acc_q[7:1] : mem_q[MEM_BYTES-1][7:1], btn};

  always_comb begin
    case (state_q)
      ST_EXEC: cur = ST_EXEC;
      ST_HALT: cur = ST_HALT;
      default: cur = ST_FETCH;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    mem_we  = 1'b0;
    mem_wa  = ir_q[4:0];
    case (cur)
      ST_FETCH: begin
        ir_d    = rd_pc;
        pc_d    = pc_q + 5'd1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        // C0-DF decode as NOPI/LUI, shadowing the XOR encoding of that range
        if (ir_q[7:4] == GRP_F) begin
          case (ir_q[3:0])
            F_JMP:  pc_d = acc_q[4:0];
            F_NOP:  ;
            F_BEQF: if (acc_q == '0) pc_d = pc_q + 5'd1;
            F_BEQB: if (acc_q == '0) pc_d = pc_q - 5'd3;
            F_BNEF: if (acc_q != '0) pc_d = pc_q + 5'd1;
            F_BNEB: if (acc_q != '0) pc_d = pc_q - 5'd3;
            F_SHL:  acc_d = {acc_q[6:0], 1'b0};
            F_SHR:  acc_d = {1'b0, acc_q[7:1]};
            F_SHL4: acc_d = {acc_q[3:0], 4'h0};
            F_ROL:  acc_d = {acc_q[6:0], acc_q[7]};
            F_ROR:  acc_d = {acc_q[0], acc_q[7:1]};
            F_LDAR: acc_d = rd_acc;
            F_DEC:  acc_d = acc_q - 8'd1;
            F_CLR:  acc_d = '0;
            F_INV:  acc_d = ~acc_q;
            F_HLT:  state_d = ST_HALT;
            default: ;
          endcase
        end else if (ir_q[7:4] == GRP_ADDI) begin
          acc_d = acc_q + {4'h0, ir_q[3:0]};
        end else if (ir_q[7:4] == GRP_LUI) begin
          acc_d = {ir_q[3:0], 4'h0};
        end else if (ir_q[7:4] == GRP_NOPI) begin
          acc_d = acc_q;
        end else begin
          case (ir_q[7:5])
            OP_LDA: acc_d = rd_a;
            OP_STA: mem_we = 1'b1;
            OP_ADD: acc_d = acc_q + rd_a;
            OP_SUB: acc_d = acc_q - rd_a;
            OP_AND: acc_d = acc_q & rd_a;
            OP_OR:  acc_d = acc_q | rd_a;
            OP_XOR: acc_d = acc_q ^ rd_a;
            default: ;
          endcase
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  assign halted    = (state_q == ST_HALT);
  assign tt.io_out = {scan_en ? sc_mem[MEM_BYTES-1] : halted, mem_q[MEM_BYTES-1][7:1]};

endmodule

// File: tb/tb_kiwih_qtcore_tt_top.sv
// Self-checking bench for kiwih_qtcore_tt_top: scan load/readback against an
// instruction-level reference model.
module tb_kiwih_qtcore_tt_top;

  logic clk = 1'b0, rst_n = 1'b0, scan_en_n = 1'b1, proc_en_n = 1'b1;
  logic scan_in = 1'b0, btn = 1'b0;

  kiwih_qtcore_tt_if pins ();
  assign pins.io_in = {2'b00, btn, scan_in, proc_en_n, scan_en_n, rst_n, clk};

  kiwih_qtcore_tt_top dut (.tt(pins));

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  bit [7:0] m_mem [17];
  bit [4:0] m_pc;
  bit [7:0] m_ir, m_acc;
  bit       m_halt;
  logic [159:0] got, dummy;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit [7:0] m_rd(input bit [4:0] a);
    int ai = int'(a);
    if (ai < 17) return m_mem[ai];
    return 8'h00;
  endfunction

  task automatic m_wr(input bit [4:0] a);
    int ai = int'(a);
    if (ai < 16) m_mem[ai] = m_acc;
    else if (ai == 16) m_mem[16][7:1] = m_acc[7:1];
  endtask

  // One whole instruction: fetch then execute.
  task automatic m_step();
    bit [7:0] op, v;
    if (m_halt) return;
    m_ir = m_rd(m_pc);
    m_pc = m_pc + 5'd1;
    op = m_ir;
    v  = m_rd(op[4:0]);
    if (op >= 8'hF0) begin
      case (op[3:0])
        4'h0: m_pc = m_acc[4:0];
        4'h2: if (m_acc == 0) m_pc = m_pc + 5'd1;
        4'h3: if (m_acc == 0) m_pc = m_pc - 5'd3;
        4'h4: if (m_acc != 0) m_pc = m_pc + 5'd1;
        4'h5: if (m_acc != 0) m_pc = m_pc - 5'd3;
        4'h6: m_acc = m_acc << 1;
        4'h7: m_acc = m_acc >> 1;
        4'h8: m_acc = m_acc << 4;
        4'h9: m_acc = (m_acc << 1) | (m_acc >> 7);
        4'hA: m_acc = (m_acc >> 1) | (m_acc << 7);
        4'hB: m_acc = m_rd(m_acc[4:0]);
        4'hC: m_acc = m_acc - 8'd1;
        4'hD: m_acc = 8'h00;
        4'hE: m_acc = ~m_acc;
        4'hF: m_halt = 1'b1;
        default: ;
      endcase
    end else if (op >= 8'hE0) m_acc = m_acc + {4'h0, op[3:0]};
    else if (op >= 8'hD0)     m_acc = {op[3:0], 4'h0};
    else if (op >= 8'hC0)     m_acc = m_acc;
    else begin
      case (op[7:5])
        3'd0: m_acc = v;
        3'd1: m_wr(op[4:0]);
        3'd2: m_acc = m_acc + v;
        3'd3: m_acc = m_acc - v;
        3'd4: m_acc = m_acc & v;
        3'd5: m_acc = m_acc | v;
        default: m_acc = m_acc ^ v;
      endcase
    end
  endtask

  function automatic logic [159:0] m_pack();
    logic [159:0] s;
    s[2:0]   = m_halt ? 3'b100 : 3'b001;
    s[7:3]   = m_pc;
    s[15:8]  = m_ir;
    s[23:16] = m_acc;
    for (int n = 0; n < 17; n++) s[24 + 8*n +: 8] = m_mem[n];
    return s;
  endfunction

  task automatic m_clear();
    for (int n = 0; n < 17; n++) m_mem[n] = 8'h00;
    m_pc = 5'd0; m_ir = 8'h00; m_acc = 8'h00; m_halt = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shift the full chain; circular mode feeds the tail back so state survives.
  task automatic scan(input bit circ, input logic [159:0] din, output logic [159:0] dout);
    scan_en_n = 1'b0;
    #1;
    for (int i = 159; i >= 0; i--) begin
      dout[i] = pins.io_out[7];
      scan_in = circ ? pins.io_out[7] : din[i];
      tick();
    end
    scan_en_n = 1'b1;
    scan_in   = 1'b0;
    #1;
  endtask

  task automatic run(input int n);
    proc_en_n = 1'b0;
    repeat (n) tick();
    proc_en_n = 1'b1;
  endtask

  initial begin
    bit [7:0] prog [16] = '{8'h0F, 8'hF2, 8'hFC, 8'h2F, 8'hF5, 8'hEF, 8'hF8, 8'hEF,
                            8'hE1, 8'h2E, 8'hF3, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h10};
    int steps;

    #12 rst_n = 1'b1;
    tick();

    // Reset state
    check("reset_io_out", 160'(pins.io_out), 160'(8'h00));
    scan(1'b1, '0, got);
    check("reset_chain", got, 160'h1);

    // Directed ADDI sequence
    m_clear();
    m_pc = 5'd1; m_ir = 8'hE0; m_acc = 8'h01; m_mem[16] = 8'hF0;
    for (int n = 0; n < 5; n++) m_mem[n] = 8'(8'hE0 + n);
    scan(1'b0, m_pack(), dummy);
    check("load_leds", 160'(pins.io_out[6:0]), 160'(7'b1111000));
    scan(1'b1, '0, got);
    check("load_chain", got, m_pack());
    run(8);
    repeat (4) m_step();
    scan(1'b1, '0, got);
    check("addi_acc", 160'(got[23:16]), 160'(8'h0B));
    check("addi_pc", 160'(got[7:3]), 160'(5'd5));
    check("addi_ir", 160'(got[15:8]), 160'(8'hE4));
    check("addi_state", 160'(got[2:0]), 160'(3'b001));
    check("addi_chain", got, m_pack());

    // Countdown loop program
    m_clear();
    for (int n = 0; n < 16; n++) m_mem[n] = prog[n];
    scan(1'b0, m_pack(), dummy);
    run(119);
    check("prog_not_halted", 160'(pins.io_out[7]), 160'(1'b0));
    run(1);
    check("prog_halted", 160'(pins.io_out[7]), 160'(1'b1));
    steps = 0;
    while (!m_halt && steps < 200) begin m_step(); steps++; end
    scan(1'b1, '0, got);
    check("prog_m15", 160'(got[24 + 8*15 +: 8]), 160'(8'h00));
    check("prog_m14", 160'(got[24 + 8*14 +: 8]), 160'(8'h01));
    check("prog_chain", got, m_pack());

    // ADDI wrap
    m_clear();
    m_mem[0] = 8'hE8; m_acc = 8'hFC;
    scan(1'b0, m_pack(), dummy);
    run(2);
    m_step();
    scan(1'b1, '0, got);
    check("addi_wrap_acc", 160'(got[23:16]), 160'(8'h04));
    check("addi_wrap_chain", got, m_pack());

    // STA to IO
    m_clear();
    m_mem[0] = 8'h30; m_acc = 8'hA5;
    scan(1'b0, m_pack(), dummy);
    run(2);
    m_step();
    check("sta_io_leds", 160'(pins.io_out[6:0]), 160'(7'b1010010));

    // HLT freeze
    m_clear();
    m_mem[0] = 8'hFF; m_acc = 8'h37;
    scan(1'b0, m_pack(), dummy);
    run(2);
    m_step();
    check("hlt_flag", 160'(pins.io_out[7]), 160'(1'b1));
    run(10);
    check("hlt_flag_hold", 160'(pins.io_out[7]), 160'(1'b1));
    scan(1'b1, '0, got);
    check("hlt_pc", 160'(got[7:3]), 160'(5'd1));
    check("hlt_acc", 160'(got[23:16]), 160'(8'h37));
    check("hlt_chain", got, m_pack());
    scan_en_n = 1'b0;
    #1;
    check("hlt_scan_tail", 160'(pins.io_out[7]), 160'(m_mem[16][7]));
    scan_en_n = 1'b1;
    #1;

    // Random programs, CPU enabled during load to exercise scan priority
    for (int it = 0; it < 25; it++) begin
      int nins;
      m_clear();
      for (int n = 0; n < 16; n++) begin
        bit [7:0] b = 8'($urandom);
        if (b[7:5] == 3'b110) b = b ^ 8'h20;
        m_mem[n] = b;
      end
      btn = 1'($urandom);
      m_mem[16] = {7'($urandom), btn};
      m_pc  = 5'($urandom);
      m_ir  = 8'($urandom);
      m_acc = 8'($urandom);
      proc_en_n = 1'b0;
      scan(1'b0, m_pack(), dummy);
      nins = int'($urandom_range(1, 30));
      run(2 * nins);
      repeat (3) tick();
      repeat (nins) m_step();
      check($sformatf("rnd%0d_io_out", it), 160'(pins.io_out), 160'({m_halt, m_mem[16][7:1]}));
      scan(1'b1, '0, got);
      check($sformatf("rnd%0d_chain", it), got, m_pack());
    end
    btn = 1'b0;

    // Async reset in the middle of a shift
    scan_en_n = 1'b0;
    scan_in   = 1'b1;
    repeat (50) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midscan_rst_io_out", 160'(pins.io_out), 160'(8'h00));
    scan_en_n = 1'b1;
    scan_in   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    scan(1'b1, '0, got);
    check("midscan_rst_chain", got, 160'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

endmodule
